ppt_button_events: RTL

//  Input-conditioning stage for the presentation controller: synchronises raw push-button pins (ui_in),

---
 rtl/ppt_button_events.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ppt_button_events.sv
// ppt_button_events: push-button input conditioning for the presentation controller.
// Each raw pin is synchronised (2 FFs) and debounced. Every debounced press queues one
// key event: at most one per button pending, plus one in the valid/ready output register.
// A press that finds its button already pending is discarded and flagged on evt_drop.
// Optional feature macro: AUTOREPEAT_EN enables a shared auto-repeat timer for the most
// recently pressed button. With AUTOREPEAT_EN undefined there is no timer logic.
module ppt_button_events #(
    parameter int unsigned N_BTN           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD   = 125000,
    localparam int unsigned CODE_W         = $clog2(N_BTN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_raw,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    input  logic              evt_ready,
    output logic [N_BTN-1:0]  btn_level,
    output logic              evt_drop
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter range check.
    if (N_BTN < 2 || N_BTN > 16 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("ppt_button_events: parameter out of range");
    end

    logic [N_BTN-1:0]  sync_s1;
    logic [N_BTN-1:0]  sync_s2;
    logic [CNT_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0]  diff_vec;
    logic [N_BTN-1:0]  hit_vec;
    logic [N_BTN-1:0]  press_vec;
    logic [N_BTN-1:0]  rep_vec;
    logic [N_BTN-1:0]  set_vec;
    logic [N_BTN-1:0]  pending;
    logic [N_BTN-1:0]  clr_mask;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;
    logic              load_slot;

    // Debounce decision: a level flips when the mismatch has lasted DEBOUNCE_CYCLES samples.
    always_comb begin
        diff_vec = sync_s2 ^ btn_level;
        hit_vec  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            hit_vec[i] = diff_vec[i] && (db_cnt[i] == CNT_LAST);
        end
        press_vec = hit_vec & sync_s2;
    end

    // Synchroniser and per-button debounce counters / levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1   <= '0;
            sync_s2   <= '0;
            btn_level <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_s1 <= btn_raw;
            sync_s2 <= sync_s1;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (!diff_vec[i]) begin
                    db_cnt[i] <= '0;
                end else if (hit_vec[i]) begin
                    db_cnt[i]    <= '0;
                    btn_level[i] <= sync_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Output slot arbitration: lowest pending index wins whenever the slot can be refilled.
    always_comb begin
        load_slot = !evt_valid || evt_ready;
        pick_any  = 1'b0;
        pick_idx  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (pending[i] && !pick_any) begin
                pick_any = 1'b1;
                pick_idx = CODE_W'(i);
            end
        end
        clr_mask = '0;
        if (load_slot && pick_any) begin
            clr_mask[pick_idx] = 1'b1;
        end
        set_vec = press_vec | rep_vec;
    end

    // Pending mask, drop flag and output register. The clear of the outgoing event is
    // applied before the new set, so a same-edge re-press keeps its bit and is not a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_drop  <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_mask) | set_vec;
            evt_drop <= |(set_vec & pending & ~clr_mask);
            if (load_slot) begin
                evt_valid <= pick_any;
                if (pick_any) begin
                    evt_code <= pick_idx;
                end
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_WAIT_FIRST,
        RPT_WAIT_NEXT
    } rpt_state_t;

    rpt_state_t        rpt_state;
    logic [RPT_W-1:0]  rpt_timer;
    logic [CODE_W-1:0] rpt_idx;
    logic [CODE_W-1:0] hi_idx;
    logic [N_BTN-1:0]  rel_vec;
    logic              rpt_at_limit;
    logic              rpt_fire;

    // Repeat timing: highest newly pressed index, limit check, and the injected repeat press.
    // A real press on the same edge restarts tracking instead of firing.
    always_comb begin
        rel_vec = hit_vec & ~sync_s2;
        hi_idx  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (press_vec[i]) begin
                hi_idx = CODE_W'(i);
            end
        end
        rpt_at_limit = (rpt_state == RPT_WAIT_FIRST) ? (rpt_timer == RPT_W'(REPEAT_DELAY - 1))
                                                     : (rpt_timer == RPT_W'(REPEAT_PERIOD - 1));
        rpt_fire = (rpt_state != RPT_IDLE) && rpt_at_limit && btn_level[rpt_idx] &&
                   !rel_vec[rpt_idx] && !(|press_vec);
        rep_vec = '0;
        if (rpt_fire) begin
            rep_vec[rpt_idx] = 1'b1;
        end
    end

    // Repeat tracker FSM: follows the most recent press until it is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_state <= RPT_IDLE;
            rpt_timer <= '0;
            rpt_idx   <= '0;
        end else if (|press_vec) begin
            rpt_state <= RPT_WAIT_FIRST;
            rpt_timer <= '0;
            rpt_idx   <= hi_idx;
        end else if (rpt_state != RPT_IDLE) begin
            if (rel_vec[rpt_idx] || !btn_level[rpt_idx]) begin
                rpt_state <= RPT_IDLE;
                rpt_timer <= '0;
            end else if (rpt_fire) begin
                rpt_state <= RPT_WAIT_NEXT;
                rpt_timer <= '0;
            end else begin
                rpt_timer <= rpt_timer + RPT_W'(1);
            end
        end
    end
`else
    assign rep_vec = '0;
`endif

endmodule
